// File: rtl/fifo_pkg.sv
// fifo_pkg: shared depth limits and pointer-width helper for the DRAM-backed FIFO.
// Contents:
//   fifo_depth_min / fifo_depth_max - legal range for the fifo_depth parameter
//   clogb2(value)                   - ceil(log2(value)), used to size pointers and counts
package fifo_pkg;

    localparam int fifo_depth_min = 4;
    localparam int fifo_depth_max = 1024;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_dram_ctrl.sv
// fifo_dram_ctrl: first-word-fall-through FIFO controller around an external
// simple dual-port distributed RAM (asynchronous read, no output register).
// Capacity is fifo_depth words in RAM plus one word in the m_data register.
// Ports:
//   clk, rst_n                     - rising-edge clock, asynchronous active-low reset
//   s_data, s_valid, s_ready       - write side handshake
//   m_data, m_valid, m_ready       - read side handshake, m_data registered
//   mem_wen, mem_waddr, mem_din    - RAM write port
//   mem_ren, mem_raddr, mem_dout   - RAM read port (mem_dout combinational from mem_raddr)
//   data_cnt                       - total words held (RAM + output register), only
//                                    present when FIFO_DATA_CNT_EN is defined
module fifo_dram_ctrl
    import fifo_pkg::*;
#(
    parameter int  fifo_depth       = 32,
    parameter int  fifo_data_width  = 24,
    parameter real simulation_delay = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [fifo_data_width-1:0]       s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [fifo_data_width-1:0]       m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             mem_wen,
    output logic [clogb2(fifo_depth)-1:0]    mem_waddr,
    output logic [fifo_data_width-1:0]       mem_din,
    output logic                             mem_ren,
    output logic [clogb2(fifo_depth)-1:0]    mem_raddr,
`ifdef FIFO_DATA_CNT_EN
    output logic [clogb2(fifo_depth):0]      data_cnt,
`endif
    input  logic [fifo_data_width-1:0]       mem_dout
);

    localparam int aw = clogb2(fifo_depth);
    localparam logic [aw:0] depth_cnt = (aw + 1)'(fifo_depth);

    // Reject illegal configurations at elaboration time.
    if (fifo_depth < fifo_depth_min || fifo_depth > fifo_depth_max ||
        (fifo_depth & (fifo_depth - 1)) != 0 || simulation_delay < 0.0) begin : g_bad_cfg
        $error("fifo_dram_ctrl: illegal fifo_depth or simulation_delay");
    end

    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;
    logic [aw:0]   mem_cnt;
    logic [aw:0]   mem_cnt_nxt;
    logic          wr;
    logic          m_valid_nxt;

    assign s_ready   = mem_cnt != depth_cnt;
    assign wr        = s_valid && s_ready;
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign mem_ren   = (mem_cnt != '0) && (!m_valid || m_ready);
    assign mem_wen   = wr;
    assign mem_waddr = wptr;
    assign mem_din   = s_data;
    assign mem_raddr = rptr;

    always_comb begin
        mem_cnt_nxt = (wr && !mem_ren) ? mem_cnt + 1'b1 :
                      (!wr && mem_ren) ? mem_cnt - 1'b1 : mem_cnt;
        m_valid_nxt = mem_ren ? 1'b1 : m_ready ? 1'b0 : m_valid;
    end

    // Pointers wrap naturally because fifo_depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            mem_cnt <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (mem_ren) begin
                rptr   <= rptr + 1'b1;
                m_data <= mem_dout;
            end
            m_valid <= m_valid_nxt;
            mem_cnt <= mem_cnt_nxt;
        end
    end

`ifdef FIFO_DATA_CNT_EN
    // Registered from next-state values so it tracks mem_cnt + m_valid exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_cnt <= '0;
        else        data_cnt <= mem_cnt_nxt + (aw + 1)'(m_valid_nxt);
    end
`endif

endmodule
